traffic_phase_sequencer: RTL



---
 rtl/traffic_pkg.sv | 15 +
 rtl/sec_prescaler.sv | 29 ++
 rtl/traffic_phase_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the intersection controller: interval state and phase index sizing.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN   = 2'd0,
        YELLOW  = 2'd1,
        ALL_RED = 2'd2
    } phase_state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to a one-cycle pulse every CLK_PER_SEC clocks.
module sec_prescaler
    import traffic_pkg::*;
#(
    parameter int unsigned CLK_PER_SEC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned   CW   = idx_w(CLK_PER_SEC);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_SEC - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// N-phase signal controller: green/yellow/all-red per phase with demand latching,
// green truncation on competing demand and skipping of phases nobody is waiting on.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned           NUM_PHASES    = 4,
    parameter int unsigned           CLK_PER_SEC   = 1000,
    parameter int unsigned           GREEN_SEC     = 120,
    parameter int unsigned           MIN_GREEN_SEC = 30,
    parameter int unsigned           YELLOW_SEC    = 4,
    parameter int unsigned           ALL_RED_SEC   = 2,
    parameter logic [NUM_PHASES-1:0] PED_MASK      = NUM_PHASES'(4'b0101),
    parameter int unsigned           TIMER_W       = 7
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_PHASES-1:0]             demand,
    output logic [NUM_PHASES-1:0]             green,
    output logic [NUM_PHASES-1:0]             yellow,
    output logic [NUM_PHASES-1:0]             red,
    output logic [NUM_PHASES-1:0]             walk,
    output logic [idx_w(NUM_PHASES)-1:0]      active_phase,
    output logic [TIMER_W-1:0]                seconds_left,
    output logic                              sec_tick
);

    localparam int unsigned        PW      = idx_w(NUM_PHASES);
    localparam logic [TIMER_W-1:0] ONE_T   = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] GREEN_T = TIMER_W'(GREEN_SEC);
    localparam logic [TIMER_W-1:0] MIN_T   = TIMER_W'(MIN_GREEN_SEC);
    localparam logic [TIMER_W-1:0] YEL_T   = TIMER_W'(YELLOW_SEC);
    localparam logic [TIMER_W-1:0] RED_T   = TIMER_W'(ALL_RED_SEC);

    phase_state_e            state_q, state_d;
    logic [PW-1:0]           phase_q, phase_d;
    logic [TIMER_W-1:0]      secs_q, secs_d;
    logic [NUM_PHASES-1:0]   req_q, req_d;
    logic [NUM_PHASES-1:0]   phase_oh;
    logic [PW-1:0]           nxt_phase;
    logic                    tick;

    sec_prescaler #(
        .CLK_PER_SEC (CLK_PER_SEC)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Rotate the request vector so the scan starts just after cur, then take the
    // lowest set bit; with no requests the scan start itself is the fallback.
    function automatic logic [PW-1:0] next_phase(input logic [PW-1:0]         cur,
                                                 input logic [NUM_PHASES-1:0] req);
        logic [2*NUM_PHASES-1:0] dbl;
        logic [NUM_PHASES-1:0]   rot;
        int unsigned             base;
        int unsigned             cand;
        int unsigned             idx;
        logic                    found;
        base  = 32'(cur) + 32'd1;
        dbl   = {req, req} >> base;
        rot   = dbl[NUM_PHASES-1:0];
        idx   = base;
        cand  = base;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_PHASES; i++) begin
            if (!found && rot[0]) begin
                idx   = cand;
                found = 1'b1;
            end
            rot  = rot >> 1;
            cand = cand + 32'd1;
        end
        if (idx >= NUM_PHASES) begin
            idx = idx - NUM_PHASES;
        end
        return PW'(idx);
    endfunction

    assign phase_oh     = NUM_PHASES'(1) << phase_q;
    assign nxt_phase    = next_phase(phase_q, req_q);
    assign green        = (state_q == GREEN)  ? phase_oh : '0;
    assign yellow       = (state_q == YELLOW) ? phase_oh : '0;
    assign red          = ~(green | yellow);
    assign walk         = (secs_q > YEL_T) ? (green & PED_MASK) : '0;
    assign active_phase = phase_q;
    assign seconds_left = secs_q;
    assign sec_tick     = tick;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= GREEN;
            phase_q <= '0;
            secs_q  <= GREEN_T;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            secs_q  <= secs_d;
            req_q   <= req_d;
        end
    end

    // Interval timing, phase advance and demand latch update.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        secs_d  = secs_q;
        req_d   = req_q | (demand & ~green);
        if (tick) begin
            if ((state_q == GREEN) && (|(req_q & ~phase_oh)) && (secs_q > MIN_T)) begin
                secs_d = MIN_T;
            end else if (secs_q > ONE_T) begin
                secs_d = secs_q - ONE_T;
            end else begin
                unique case (state_q)
                    GREEN: begin
                        state_d = YELLOW;
                        secs_d  = YEL_T;
                    end
                    YELLOW: begin
                        state_d = ALL_RED;
                        secs_d  = RED_T;
                    end
                    ALL_RED: begin
                        state_d = GREEN;
                        phase_d = nxt_phase;
                        secs_d  = GREEN_T;
                        req_d   = req_d & ~(NUM_PHASES'(1) << nxt_phase);
                    end
                    default: begin
                        state_d = GREEN;
                        secs_d  = GREEN_T;
                    end
                endcase
            end
        end
    end

endmodule
